// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, frame totals, colour-bar table, sync polarity helper
package vga_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    // {r,g,b} on/off per bar, bar 0 (leftmost) in the lowest slot:
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                           3'b010, 3'b011, 3'b110, 3'b111};
    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
    function automatic logic sync_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit, D-deep enabled shift register with async reset value; D=0 is a wire
// Ports: clk, rst (async, active-high), en (advance), d (input word), q (word delayed D enabled cycles)
module vga_delay_line #(
    parameter int W = 1,
    parameter int D = 0,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (D == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst, en};
        assign q = d;
    end else begin : g_sr
        logic [W-1:0] sr [D];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < D; i++) sr[i] <= RST_VAL;
            end else if (en) begin
                sr[0] <= d;
                for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
            end
        end
        assign q = sr[D-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with renderer-latency-compensated sync/de/colour
// Ports: clk, rst (async, active-high), en (pixel enable); screen_x/screen_y, coord_valid,
//   line_start, frame_start to the renderer; rin/gin/bin colour back from it;
//   h_sync, v_sync, de, r, g, b registered pins.
// Build option: VGA_TIMING_TEST_PATTERN_EN adds test_en, replacing renderer colour with 8 bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 8,
    parameter int PIPE_LAT = 2,
    parameter int X_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    input  logic               test_en,
`endif
    output logic [X_W-1:0]     screen_x,
    output logic [X_W-1:0]     screen_y,
    output logic               coord_valid,
    output logic               line_start,
    output logic               frame_start,
    input  logic [COLOR_W-1:0] rin,
    input  logic [COLOR_W-1:0] gin,
    input  logic [COLOR_W-1:0] bin,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] V_LAST   = X_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] V_ACT    = X_W'(V_ACTIVE);
    localparam logic [X_W-1:0] HS_FIRST = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [X_W-1:0] VS_FIRST = X_W'(V_ACTIVE + V_FP);
    localparam logic [X_W-1:0] VS_LAST  = X_W'(V_ACTIVE + V_FP + V_SYNC - 1);
`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int DW = 3 + X_W;
`else
    localparam int DW = 3;
`endif
    logic [DW-1:0] dly_in, dly_out;
    logic raw_hs, raw_vs, d_hs, d_vs, d_de;
    logic [COLOR_W-1:0] r_sel, g_sel, b_sel;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            screen_x <= '0;
            screen_y <= '0;
        end else if (en) begin
            screen_x <= screen_x == H_LAST ? '0 : screen_x + 1'b1;
            if (screen_x == H_LAST) screen_y <= screen_y == V_LAST ? '0 : screen_y + 1'b1;
        end
    end
    assign coord_valid = screen_x < H_ACT && screen_y < V_ACT;
    assign line_start  = screen_x == '0;
    assign frame_start = line_start && screen_y == '0;
    // delay line carries logical "asserted" syncs; polarity is applied at the pin register
    assign raw_hs = screen_x >= HS_FIRST && screen_x <= HS_LAST;
    assign raw_vs = screen_y >= VS_FIRST && screen_y <= VS_LAST;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    assign dly_in = {raw_hs, raw_vs, coord_valid, screen_x};
`else
    assign dly_in = {raw_hs, raw_vs, coord_valid};
`endif
    vga_delay_line #(.W(DW), .D(PIPE_LAT)) u_dly (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (dly_in),
        .q   (dly_out)
    );
    assign {d_hs, d_vs, d_de} = dly_out[DW-1 -: 3];
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [X_W-1:0] d_x;
    logic [2:0] bar_idx, bar;
    assign d_x     = dly_out[X_W-1:0];
    assign bar_idx = 3'(d_x / X_W'(H_ACTIVE / 8));
    assign bar     = BAR_RGB[bar_idx];
    assign r_sel   = test_en ? {COLOR_W{bar[2]}} : rin;
    assign g_sel   = test_en ? {COLOR_W{bar[1]}} : gin;
    assign b_sel   = test_en ? {COLOR_W{bar[0]}} : bin;
`else
    assign r_sel = rin;
    assign g_sel = gin;
    assign b_sel = bin;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_sync <= ~HS_POL;
            v_sync <= ~VS_POL;
            de     <= 1'b0;
            r      <= '0;
            g      <= '0;
            b      <= '0;
        end else if (en) begin
            h_sync <= sync_level(d_hs, HS_POL);
            v_sync <= sync_level(d_vs, VS_POL);
            de     <= d_de;
            r      <= d_de ? r_sel : '0;
            g      <= d_de ? g_sel : '0;
            b      <= d_de ? b_sel : '0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a small-timing VGA generator against a cycle model
module tb_vga_timing_gen;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = 24;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, en = 1'b1, test_en = 1'b0;
    logic [7:0] sx, sy, sx2, sy2, rin, gin, bin, r, g, b, r2, g2, b2, p1, p2;
    logic cv, ls, fs, cv2, ls2, fs2, hs, vs, de, hs2, vs2, de2;
    int checks = 0, errors = 0, cyc = 0, ex = 0, ey = 0;
    logic sh [3], sv [3], sd [3];
    logic [7:0] sxq [3];
    logic te_last = 1'b0, ph = 1'b1, pv = 1'b1, pd = 1'b0;
    int hs_f[$], hs_r[$], vs_f[$], vs_r[$], de_r[$];

    always #5 clk = ~clk;

    // model renderer with two enabled cycles of latency, r = x
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= '0;
            p2 <= '0;
        end else if (en) begin
            p1 <= sx;
            p2 <= p1;
        end
    end
    assign rin = p2;
    assign gin = ~p2;
    assign bin = 8'h5a;

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
        .V_SYNC(VS), .V_BP(VB), .COLOR_W(8), .PIPE_LAT(2), .X_W(8)) dut (
        .clk(clk), .rst(rst), .en(en),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .screen_x(sx), .screen_y(sy), .coord_valid(cv), .line_start(ls), .frame_start(fs),
        .rin(rin), .gin(gin), .bin(bin), .h_sync(hs), .v_sync(vs), .de(de), .r(r), .g(g), .b(b));

    // positive polarity, zero-latency renderer (colour is combinational from x)
    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
        .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8), .PIPE_LAT(0), .X_W(8)) dut_p (
        .clk(clk), .rst(rst), .en(en),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .test_en(test_en),
`endif
        .screen_x(sx2), .screen_y(sy2), .coord_valid(cv2), .line_start(ls2), .frame_start(fs2),
        .rin(sx2), .gin(~sx2), .bin(8'h5a), .h_sync(hs2), .v_sync(vs2), .de(de2), .r(r2), .g(g2), .b(b2));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    function automatic int exp_rgb(input logic dd, input logic [7:0] xv, input logic t);
        logic [2:0] c;
        if (!dd) return 0;
        if (!t) return int'({xv, ~xv, 8'h5a});
        case (xv / 2)
            0: c = 3'b111;
            1: c = 3'b110;
            2: c = 3'b011;
            3: c = 3'b010;
            4: c = 3'b101;
            5: c = 3'b100;
            6: c = 3'b001;
            default: c = 3'b000;
        endcase
        return int'({{8{c[2]}}, {8{c[1]}}, {8{c[0]}}});
    endfunction

    task automatic check_outputs();
        chk("x", int'(sx), ex);
        chk("y", int'(sy), ey);
        chk("coord_valid", int'(cv), int'(ex < HA && ey < VA));
        chk("line_start", int'(ls), int'(ex == 0));
        chk("frame_start", int'(fs), int'(ex == 0 && ey == 0));
        chk("h_sync", int'(hs), int'(!sh[2]));
        chk("v_sync", int'(vs), int'(!sv[2]));
        chk("de", int'(de), int'(sd[2]));
        chk("rgb", int'({r, g, b}), exp_rgb(sd[2], sxq[2], te_last));
        chk("x_p", int'(sx2), ex);
        chk("y_p", int'(sy2), ey);
        chk("flags_p", int'({cv2, ls2, fs2}), int'({cv, ls, fs}));
        chk("h_sync_p", int'(hs2), int'(sh[0]));
        chk("v_sync_p", int'(vs2), int'(sv[0]));
        chk("de_p", int'(de2), int'(sd[0]));
        chk("rgb_p", int'({r2, g2, b2}), exp_rgb(sd[0], sxq[0], te_last));
    endtask

    task automatic clear_edges();
        hs_f.delete(); hs_r.delete(); vs_f.delete(); vs_r.delete(); de_r.delete();
        ph = hs; pv = vs; pd = de;
    endtask

    task automatic step();
        logic t;
        t = TP && test_en;
        @(posedge clk); #1;
        cyc++;
        if (en) begin
            for (int i = 2; i > 0; i--) begin
                sh[i] = sh[i-1]; sv[i] = sv[i-1]; sd[i] = sd[i-1]; sxq[i] = sxq[i-1];
            end
            sh[0] = ex >= HA + HF && ex < HA + HF + HS;
            sv[0] = ey >= VA + VF && ey < VA + VF + VS;
            sd[0] = ex < HA && ey < VA;
            sxq[0] = 8'(ex);
            te_last = t;
            if (ex == HT - 1) begin
                ex = 0;
                ey = ey == VT - 1 ? 0 : ey + 1;
            end else ex++;
        end
        check_outputs();
        if (ph && !hs) hs_f.push_back(cyc);
        if (!ph && hs) hs_r.push_back(cyc);
        if (pv && !vs) vs_f.push_back(cyc);
        if (!pv && vs) vs_r.push_back(cyc);
        if (!pd && de) de_r.push_back(cyc);
        ph = hs; pv = vs; pd = de;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        ex = 0; ey = 0; te_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sh[i] = 1'b0; sv[i] = 1'b0; sd[i] = 1'b0; sxq[i] = '0;
        end
        check_outputs();
        @(posedge clk); #1;
        check_outputs();
        rst = 1'b0;
        cyc = 0;
        clear_edges();
    endtask

    initial begin
        logic found;
        #3;
        do_reset();
        for (int i = 0; i < 330; i++) step();
        chk("first_de", qat(de_r, 0), 3);
        chk("hs_first_fall", qat(hs_f, 0), HA + HF + 3);
        chk("hs_low_len", qat(hs_r, 0) - qat(hs_f, 0), HS);
        chk("line_period", qat(hs_f, 1) - qat(hs_f, 0), HT);
        chk("vs_first_fall", qat(vs_f, 0), (VA + VF) * HT + 3);
        chk("vs_low_len", qat(vs_r, 0) - qat(vs_f, 0), VS * HT);
        chk("frame_period", qat(vs_f, 1) - qat(vs_f, 0), HT * VT);
        test_en = 1'b1;
        for (int i = 0; i < 60; i++) step();
        test_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        clear_edges();
        for (int i = 0; i < 160; i++) begin
            en = (i % 2) == 1;
            step();
        end
        en = 1'b1;
        chk("line_period_half_en", qat(hs_f, 1) - qat(hs_f, 0), 2 * HT);
        chk("hs_low_half_en", qat(hs_r, 0) - qat(hs_f, 0), 2 * HS);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (ex == 10 && ey == 3) found = 1'b1;
            else step();
        end
        chk("reach_mid_frame", int'(found), 1);
        do_reset();
        for (int i = 0; i < 40; i++) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
